// File: rtl/ysyx_25060170_mem_resp_pkg.sv
// Shared types and constants for the memory responder and its word array.
package ysyx_25060170_mem_resp_pkg;

    // Responder FSM: IDLE accepts, WAIT models latency, RESP holds the answer.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } resp_state_e;

    localparam logic [31:0] DEFAULT_ADDR_BASE = 32'h8000_0000;
    localparam int          RESP_ERR_W        = 1;
    localparam int          CNT_W             = 4;   // holds LATENCY-1 for LATENCY up to 15

    // Offset is (addr - base), already wrapped; it is in range only when no
    // bit above the word-array span is set.
    function automatic logic addr_in_range(input logic [31:0] off, input int depth_log2);
        return (off >> (depth_log2 + 2)) == 32'd0;
    endfunction

endpackage

// File: rtl/ysyx_25060170_sram_array.sv
// Word array: one synchronous read port, one byte-masked synchronous write port, no reset.
module ysyx_25060170_sram_array #(
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  clk,
    input  logic                  rd_en,
    input  logic [DEPTH_LOG2-1:0] rd_idx,
    output logic [31:0]           rd_data,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_idx,
    input  logic [31:0]           wr_data,
    input  logic [3:0]            wr_mask
);

    logic [31:0] mem [0:(1 << DEPTH_LOG2) - 1];

    // Byte-lane write: only lanes whose mask bit is set are updated.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_mask[i]) begin
                    mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // Read data register only moves on a read, so it stays put while a response is held.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/ysyx_25060170_mem_resp.sv
// Single-outstanding memory responder with fixed access latency.
//
// Handshake rule (both channels): a transfer happens on a rising edge where
// valid and ready are both high. The request side may hold req_valid with any
// fields; they are captured only on that edge. Once resp_valid rises, resp_rdata
// and resp_err stay constant until the edge where resp_ready is also high.
module ysyx_25060170_mem_resp
    import ysyx_25060170_mem_resp_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE  = DEFAULT_ADDR_BASE,
    parameter int          DEPTH_LOG2 = 12,
    parameter int          LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wmask,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [1:0]  dbg_state
);

    resp_state_e      state;
    logic [CNT_W-1:0] cnt;
    logic             lat_wen;
    logic [31:0]      lat_addr;
    logic [31:0]      lat_wdata;
    logic [3:0]       lat_wmask;
    logic             rdata_ok;

    logic             accept;
    logic             commit;
    logic             acc_wen;
    logic [31:0]      acc_addr;
    logic [31:0]      acc_wdata;
    logic [3:0]       acc_wmask;
    logic [31:0]      offset;
    logic             in_range;
    logic [31:0]      sram_q;

    // With LATENCY=1 the commit edge is the accept edge, so the access fields
    // come straight from the request bus instead of the latch.
    always_comb begin
        accept    = (state == IDLE) && req_valid;
        acc_wen   = (state == IDLE) ? req_wen   : lat_wen;
        acc_addr  = (state == IDLE) ? req_addr  : lat_addr;
        acc_wdata = (state == IDLE) ? req_wdata : lat_wdata;
        acc_wmask = (state == IDLE) ? req_wmask : lat_wmask;
        commit    = (accept && (LATENCY == 1)) || ((state == WAIT) && (cnt == CNT_W'(1)));
        offset    = acc_addr - ADDR_BASE;
        in_range  = addr_in_range(offset, DEPTH_LOG2);
    end

    ysyx_25060170_sram_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_sram (
        .clk     (clk),
        .rd_en   (commit && in_range && !acc_wen && !rst),
        .rd_idx  (offset[DEPTH_LOG2+1:2]),
        .rd_data (sram_q),
        .wr_en   (commit && in_range && acc_wen && !rst),
        .wr_idx  (offset[DEPTH_LOG2+1:2]),
        .wr_data (acc_wdata),
        .wr_mask (acc_wmask)
    );

    // FSM, latency counter, request latch and registered response flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            rdata_ok   <= 1'b0;
            lat_wen    <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_wmask  <= '0;
        end else begin
            if (accept) begin
                lat_wen   <= req_wen;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                lat_wmask <= req_wmask;
                req_ready <= 1'b0;
            end
            if (commit) begin
                state      <= RESP;
                cnt        <= '0;
                resp_valid <= 1'b1;
                resp_err   <= !in_range;
                rdata_ok   <= in_range && !acc_wen;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (req_valid) begin
                            state <= WAIT;
                            cnt   <= CNT_W'(LATENCY - 1);
                        end
                    end
                    WAIT: cnt <= cnt - CNT_W'(1);
                    RESP: begin
                        if (resp_ready) begin
                            state      <= IDLE;
                            resp_valid <= 1'b0;
                            resp_err   <= 1'b0;
                            rdata_ok   <= 1'b0;
                            req_ready  <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Read data only reaches the port for in-range loads; stores and errors return 0.
    assign resp_rdata = rdata_ok ? sram_q : 32'h0;
    assign dbg_state  = state;

endmodule

// File: tb/tb_ysyx_25060170_mem_resp.sv
// Directed bench for the memory responder: main instance at LATENCY=2, plus
// LATENCY=1 and LATENCY=15 instances for response timing.
module tb_ysyx_25060170_mem_resp;
    import ysyx_25060170_mem_resp_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wen = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wmask = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [1:0]  dbg_state;

    logic        lx_valid = 1'b0;
    logic        l1_ready, l1_rvalid, l1_err;
    logic [31:0] l1_rdata;
    logic [1:0]  l1_state;
    logic        l15_ready, l15_rvalid, l15_err;
    logic [31:0] l15_rdata;
    logic [1:0]  l15_state;

    int n_checks = 0;
    int n_err    = 0;
    logic [31:0] exp_q[$];

    // Clock and reset
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    ysyx_25060170_mem_resp #(.LATENCY(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .dbg_state(dbg_state)
    );

    ysyx_25060170_mem_resp #(.LATENCY(1)) dut_l1 (
        .clk(clk), .rst(rst),
        .req_valid(lx_valid), .req_ready(l1_ready), .req_wen(1'b0),
        .req_addr(32'h8000_0000), .req_wdata(32'h0), .req_wmask(4'h0),
        .resp_valid(l1_rvalid), .resp_ready(1'b1),
        .resp_rdata(l1_rdata), .resp_err(l1_err), .dbg_state(l1_state)
    );

    ysyx_25060170_mem_resp #(.LATENCY(15)) dut_l15 (
        .clk(clk), .rst(rst),
        .req_valid(lx_valid), .req_ready(l15_ready), .req_wen(1'b0),
        .req_addr(32'h8000_0000), .req_wdata(32'h0), .req_wmask(4'h0),
        .resp_valid(l15_rvalid), .resp_ready(1'b1),
        .resp_rdata(l15_rdata), .resp_err(l15_err), .dbg_state(l15_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Driver: one full access with a LATENCY=2 timing check and prompt handshake.
    task automatic access(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wmask, output logic [31:0] rdata, output logic err);
        int n;
        req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata; req_wmask = wmask;
        n = 0;
        while (!req_ready && n < 50) begin tick(); n++; end
        check("acc_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        n = 1;
        while (!resp_valid && n < 40) begin tick(); n++; end
        check("latency", 32'(n), 32'd2);
        rdata = resp_rdata;
        err   = resp_err;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("valid_drop", 32'(resp_valid), 32'd0);
    endtask

    task automatic store(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wmask, input logic exp_err);
        logic [31:0] rd;
        logic        er;
        access(1'b1, addr, wdata, wmask, rd, er);
        check({tag, "_err"}, 32'(er), 32'(exp_err));
        check({tag, "_rdata0"}, rd, 32'h0);
    endtask

    task automatic load(input string tag, input logic [31:0] addr,
                        input logic [31:0] exp_data, input logic exp_err);
        logic [31:0] rd;
        logic        er;
        exp_q.push_back(exp_data);
        access(1'b0, addr, 32'h0, 4'h0, rd, er);
        check({tag, "_err"}, 32'(er), 32'(exp_err));
        check(tag, rd, exp_q.pop_front());
    endtask

    initial begin
        int n;
        int lat1, lat15;
        logic seen;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_rdata", resp_rdata, 32'h0);
        check("rst_err", 32'(resp_err), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));

        // Full and partial stores, read back
        store("st_full", 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0);
        load("ld_full", 32'h8000_0010, 32'hDEAD_BEEF, 1'b0);
        store("st_part", 32'h8000_0010, 32'h0000_5A00, 4'b0010, 1'b0);
        load("ld_part", 32'h8000_0010, 32'hDEAD_5AEF, 1'b0);
        load("ld_lowbits", 32'h8000_0013, 32'hDEAD_5AEF, 1'b0);

        // Range boundaries: last word in range, errors on either side, no aliasing writes
        store("st_last", 32'h8000_3FFC, 32'h0BAD_F00D, 4'hF, 1'b0);
        load("ld_below", 32'h7FFF_FFFC, 32'h0, 1'b1);
        load("ld_above", 32'h8000_4000, 32'h0, 1'b1);
        store("st_above", 32'h8000_4010, 32'hFFFF_FFFF, 4'hF, 1'b1);
        store("st_below", 32'h7FFF_FFFC, 32'h1111_1111, 4'hF, 1'b1);
        load("ld_after_above", 32'h8000_0010, 32'hDEAD_5AEF, 1'b0);
        load("ld_after_below", 32'h8000_3FFC, 32'h0BAD_F00D, 1'b0);

        // Zero-mask store is a no-op with a normal response
        store("st_mask0", 32'h8000_0010, 32'h1234_5678, 4'h0, 1'b0);
        load("ld_mask0", 32'h8000_0010, 32'hDEAD_5AEF, 1'b0);

        // Backpressure: response held 5 cycles, second request held high meanwhile
        req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0010;
        tick();
        req_addr = 32'h8000_3FFC;
        n = 1;
        while (!resp_valid && n < 40) begin tick(); n++; end
        check("hold_latency", 32'(n), 32'd2);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_valid", 32'(resp_valid), 32'd1);
            check("hold_rdata", resp_rdata, 32'hDEAD_5AEF);
            check("hold_err", 32'(resp_err), 32'd0);
            check("hold_req_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("hs_req_ready", 32'(req_ready), 32'd1);
        check("hs_valid_drop", 32'(resp_valid), 32'd0);
        tick();
        req_valid = 1'b0;
        check("second_accepted", 32'(req_ready), 32'd0);
        n = 1;
        while (!resp_valid && n < 40) begin tick(); n++; end
        check("second_latency", 32'(n), 32'd2);
        check("second_rdata", resp_rdata, 32'h0BAD_F00D);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;

        // Reset during WAIT discards a pending store
        store("st_zero20", 32'h8000_0020, 32'h0, 4'hF, 1'b0);
        req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h8000_0020;
        req_wdata = 32'h1234_5678; req_wmask = 4'hF;
        tick();
        req_valid = 1'b0;
        check("pre_rst_state", 32'(dbg_state), 32'(WAIT));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("wrst_req_ready", 32'(req_ready), 32'd1);
        check("wrst_state", 32'(dbg_state), 32'(IDLE));
        seen = resp_valid;
        for (int i = 0; i < 5; i++) begin tick(); seen = seen | resp_valid; end
        check("wrst_no_valid", 32'(seen), 32'd0);
        load("ld_after_rst", 32'h8000_0020, 32'h0, 1'b0);

        // LATENCY=1 and LATENCY=15 instances, resp_ready tied high, two loads each
        for (int r = 0; r < 2; r++) begin
            lat1 = 0; lat15 = 0;
            lx_valid = 1'b1;
            tick();
            lx_valid = 1'b0;
            for (int k = 1; k <= 20; k++) begin
                if (l1_rvalid && lat1 == 0) lat1 = k;
                if (l15_rvalid && lat15 == 0) lat15 = k;
                tick();
            end
            check("lat1", 32'(lat1), 32'd1);
            check("lat15", 32'(lat15), 32'd15);
            check("lat_idle", 32'({l1_ready, l15_ready}), 32'd3);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
